// File: rtl/tlcd_pkg.sv
// Shared definitions for the text-LCD bus: FSM encoding, command codes,
// default timing and the latched write payload.
package tlcd_pkg;

    localparam int unsigned CNT_W  = 17;
    localparam int unsigned DATA_W = 8;

    localparam logic [DATA_W-1:0] CMD_CLEAR = 8'h01;
    localparam logic [DATA_W-1:0] CMD_HOME  = 8'h02;

    localparam int unsigned T_SETUP_DEF = 2;
    localparam int unsigned T_EH_DEF    = 12;
    localparam int unsigned T_HOLD_DEF  = 2;
    localparam int unsigned T_EXEC_DEF  = 2000;
    localparam int unsigned T_CLEAR_DEF = 80000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_E_HIGH = 3'd2,
        ST_HOLD   = 3'd3,
        ST_WAIT   = 3'd4
    } state_e;

    typedef struct packed {
        logic              lock;
        logic              rs;
        logic [DATA_W-1:0] data;
    } lcd_xfer_t;

    // A phase of N cycles loads N-1; zero-length phases are stretched to one cycle.
    function automatic logic [CNT_W-1:0] dly_load(input int unsigned cycles);
        return (cycles <= 1) ? '0 : CNT_W'(cycles - 1);
    endfunction

    function automatic logic is_long_cmd(input lcd_xfer_t x);
        return !x.rs && ((x.data == CMD_CLEAR) || (x.data == CMD_HOME));
    endfunction

endpackage

// File: rtl/tlcd_delay_counter.sv
// Loadable down-counter used for every LCD bus phase; saturates at zero.
module tlcd_delay_counter
    import tlcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CNT_W-1:0] load_i,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = load_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/tlcd_bus_arbiter.sv
// Two-port arbiter with lockable grant that sequences HD44780-style writes
// (setup, E pulse, hold, execution wait) onto the shared LCD bus.
module tlcd_bus_arbiter
    import tlcd_pkg::*;
#(
    parameter int unsigned T_SETUP = T_SETUP_DEF,
    parameter int unsigned T_EH    = T_EH_DEF,
    parameter int unsigned T_HOLD  = T_HOLD_DEF,
    parameter int unsigned T_EXEC  = T_EXEC_DEF,
    parameter int unsigned T_CLEAR = T_CLEAR_DEF
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_lock,
    input  logic              req_rs0,
    input  logic              req_rs1,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic [1:0]        req_ready,
    output logic [1:0]        req_done,
    output logic              grant_owner,
    output logic              busy,
    output logic              TLCD_E,
    output logic              TLCD_RS,
    output logic              TLCD_RW,
    output logic [DATA_W-1:0] TLCD_DATA
);

    localparam logic [CNT_W-1:0] L_SETUP = dly_load(T_SETUP);
    localparam logic [CNT_W-1:0] L_EH    = dly_load(T_EH);
    localparam logic [CNT_W-1:0] L_HOLD  = dly_load(T_HOLD);
    localparam logic [CNT_W-1:0] L_EXEC  = dly_load(T_EXEC);
    localparam logic [CNT_W-1:0] L_CLEAR = dly_load(T_CLEAR);

    state_e     state_q, state_d;
    lcd_xfer_t  xfer_q, xfer_d;
    logic       owner_q, owner_d;
    logic       lock_held_q, lock_held_d;
    logic [1:0] ready_q, ready_d;
    logic [1:0] done_q, done_d;
    logic       e_q, e_d;
    logic       busy_q, busy_d;

    logic             grant_c;
    logic             win_c;
    logic             cnt_start_c;
    logic [CNT_W-1:0] cnt_load_c;
    logic             cnt_zero_c;

    tlcd_delay_counter u_delay (
        .clk     (CLK),
        .rst_n   (RESETN),
        .start_i (cnt_start_c),
        .load_i  (cnt_load_c),
        .zero_c  (cnt_zero_c)
    );

    // A held lock restricts the grant to its owner; otherwise port 0 has priority.
    always_comb begin
        grant_c = 1'b0;
        win_c   = owner_q;
        if (lock_held_q) begin
            grant_c = req_valid[owner_q];
        end else if (req_valid[0]) begin
            grant_c = 1'b1;
            win_c   = 1'b0;
        end else if (req_valid[1]) begin
            grant_c = 1'b1;
            win_c   = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        xfer_d      = xfer_q;
        owner_d     = owner_q;
        lock_held_d = lock_held_q;
        ready_d     = '0;
        done_d      = '0;
        cnt_start_c = 1'b0;
        cnt_load_c  = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_c) begin
                    state_d        = ST_SETUP;
                    owner_d        = win_c;
                    xfer_d.lock    = req_lock[win_c];
                    xfer_d.rs      = win_c ? req_rs1 : req_rs0;
                    xfer_d.data    = win_c ? req_data1 : req_data0;
                    ready_d[win_c] = 1'b1;
                    cnt_start_c    = 1'b1;
                    cnt_load_c     = L_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_zero_c) begin
                    state_d     = ST_E_HIGH;
                    cnt_start_c = 1'b1;
                    cnt_load_c  = L_EH;
                end
            end
            ST_E_HIGH: begin
                if (cnt_zero_c) begin
                    state_d     = ST_HOLD;
                    cnt_start_c = 1'b1;
                    cnt_load_c  = L_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_zero_c) begin
                    state_d     = ST_WAIT;
                    cnt_start_c = 1'b1;
                    cnt_load_c  = is_long_cmd(xfer_q) ? L_CLEAR : L_EXEC;
                end
            end
            ST_WAIT: begin
                if (cnt_zero_c) begin
                    state_d         = ST_IDLE;
                    done_d[owner_q] = 1'b1;
                    lock_held_d     = xfer_q.lock;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        e_d    = (state_d == ST_E_HIGH);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= ST_IDLE;
            xfer_q      <= '0;
            owner_q     <= 1'b0;
            lock_held_q <= 1'b0;
            ready_q     <= '0;
            done_q      <= '0;
            e_q         <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            xfer_q      <= xfer_d;
            owner_q     <= owner_d;
            lock_held_q <= lock_held_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            e_q         <= e_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready   = ready_q;
    assign req_done    = done_q;
    assign grant_owner = owner_q;
    assign busy        = busy_q;
    assign TLCD_E      = e_q;
    assign TLCD_RS     = xfer_q.rs;
    assign TLCD_RW     = 1'b0;
    assign TLCD_DATA   = xfer_q.data;

endmodule

// File: tb/tb_tlcd_bus_arbiter.sv
// Directed bench for tlcd_bus_arbiter with shortened LCD timing.
module tb_tlcd_bus_arbiter;

    localparam int unsigned SIM_SETUP = 1;
    localparam int unsigned SIM_EH    = 3;
    localparam int unsigned SIM_HOLD  = 1;
    localparam int unsigned SIM_EXEC  = 4;
    localparam int unsigned SIM_CLEAR = 20;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic [1:0] req_valid = '0;
    logic [1:0] req_lock = '0;
    logic       req_rs0 = 1'b0;
    logic       req_rs1 = 1'b0;
    logic [7:0] req_data0 = '0;
    logic [7:0] req_data1 = '0;
    logic [1:0] req_ready;
    logic [1:0] req_done;
    logic       grant_owner;
    logic       busy;
    logic       TLCD_E;
    logic       TLCD_RS;
    logic       TLCD_RW;
    logic [7:0] TLCD_DATA;

    int n_tests = 0;
    int n_fail  = 0;

    tlcd_bus_arbiter #(
        .T_SETUP (SIM_SETUP),
        .T_EH    (SIM_EH),
        .T_HOLD  (SIM_HOLD),
        .T_EXEC  (SIM_EXEC),
        .T_CLEAR (SIM_CLEAR)
    ) dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .req_valid   (req_valid),
        .req_lock    (req_lock),
        .req_rs0     (req_rs0),
        .req_rs1     (req_rs1),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .req_ready   (req_ready),
        .req_done    (req_done),
        .grant_owner (grant_owner),
        .busy        (busy),
        .TLCD_E      (TLCD_E),
        .TLCD_RS     (TLCD_RS),
        .TLCD_RW     (TLCD_RW),
        .TLCD_DATA   (TLCD_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in an IDLE cycle with port p's request already driven; walks the
    // whole write and returns in the cycle where req_done pulses.
    task automatic xfer(input logic p, input logic rs, input logic [7:0] d, input int unsigned wait_n);
        logic [1:0] pb;
        pb = p ? 2'b10 : 2'b01;
        tick();
        check("accept_ready", 32'(req_ready), 32'(pb));
        check("accept_owner", 32'(grant_owner), 32'(p));
        check("accept_busy", 32'(busy), 32'd1);
        check("setup_e", 32'(TLCD_E), 32'd0);
        check("setup_rs", 32'(TLCD_RS), 32'(rs));
        check("setup_data", 32'(TLCD_DATA), 32'(d));
        req_valid[p] = 1'b0;
        if (p) req_data1 = 8'(d + 8'd1);
        else   req_data0 = 8'(d + 8'd1);
        for (int i = 1; i < int'(SIM_SETUP); i++) tick();
        for (int i = 0; i < int'(SIM_EH); i++) begin
            tick();
            check("ehigh_e", 32'(TLCD_E), 32'd1);
            check("ehigh_data", 32'(TLCD_DATA), 32'(d));
            check("ehigh_rs", 32'(TLCD_RS), 32'(rs));
            check("ehigh_ready", 32'(req_ready), 32'd0);
        end
        tick();
        check("hold_e", 32'(TLCD_E), 32'd0);
        check("hold_data", 32'(TLCD_DATA), 32'(d));
        check("hold_rs", 32'(TLCD_RS), 32'(rs));
        for (int i = 0; i < int'(wait_n); i++) begin
            tick();
            check("wait_done", 32'(req_done), 32'd0);
            check("wait_busy", 32'(busy), 32'd1);
            check("wait_e", 32'(TLCD_E), 32'd0);
            check("wait_data", 32'(TLCD_DATA), 32'(d));
            check("wait_ready", 32'(req_ready), 32'd0);
        end
        tick();
        check("done_pulse", 32'(req_done), 32'(pb));
        check("done_busy", 32'(busy), 32'd0);
        check("done_owner", 32'(grant_owner), 32'(p));
        check("done_ready", 32'(req_ready), 32'd0);
        check("rw_low", 32'(TLCD_RW), 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_e", 32'(TLCD_E), 32'd0);
        check("rst_rs", 32'(TLCD_RS), 32'd0);
        check("rst_rw", 32'(TLCD_RW), 32'd0);
        check("rst_data", 32'(TLCD_DATA), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_done", 32'(req_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(grant_owner), 32'd0);
        RESETN = 1'b1;
        tick();

        // Single port-1 data write; incoming data changes after accept
        req_rs1 = 1'b1; req_data1 = 8'h41; req_lock[1] = 1'b0; req_valid[1] = 1'b1;
        check("single_pre_ready", 32'(req_ready), 32'd0);
        xfer(1'b1, 1'b1, 8'h41, SIM_EXEC);

        // Clear, Home and a normal command, back to back from port 0
        req_rs0 = 1'b0; req_data0 = 8'h01; req_lock[0] = 1'b0; req_valid[0] = 1'b1;
        xfer(1'b0, 1'b0, 8'h01, SIM_CLEAR);
        req_data0 = 8'h0C; req_valid[0] = 1'b1;
        xfer(1'b0, 1'b0, 8'h0C, SIM_EXEC);
        req_data0 = 8'h02; req_valid[0] = 1'b1;
        xfer(1'b0, 1'b0, 8'h02, SIM_CLEAR);
        req_rs0 = 1'b1; req_data0 = 8'h01; req_valid[0] = 1'b1;
        xfer(1'b0, 1'b1, 8'h01, SIM_EXEC);

        // Contention: port 0 first, port 1 right after its done
        req_rs0 = 1'b1; req_data0 = 8'h30;
        req_rs1 = 1'b1; req_data1 = 8'h31;
        req_valid = 2'b11;
        xfer(1'b0, 1'b1, 8'h30, SIM_EXEC);
        xfer(1'b1, 1'b1, 8'h31, SIM_EXEC);

        // Lock burst from port 0 while port 1 keeps requesting
        req_rs1 = 1'b1; req_data1 = 8'h55; req_lock[1] = 1'b0; req_valid[1] = 1'b1;
        req_rs0 = 1'b0; req_data0 = 8'h40; req_lock[0] = 1'b1; req_valid[0] = 1'b1;
        xfer(1'b0, 1'b0, 8'h40, SIM_EXEC);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("lock_idle_ready", 32'(req_ready), 32'd0);
            check("lock_idle_busy", 32'(busy), 32'd0);
            check("lock_idle_owner", 32'(grant_owner), 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            req_rs0 = 1'b1;
            req_data0 = 8'(8'h10 + i);
            req_lock[0] = (i != 7);
            req_valid[0] = 1'b1;
            xfer(1'b0, 1'b1, 8'(8'h10 + i), SIM_EXEC);
        end
        xfer(1'b1, 1'b1, 8'h55, SIM_EXEC);

        // Reset during E_HIGH
        req_rs1 = 1'b1; req_data1 = 8'h77; req_valid[1] = 1'b1;
        tick();
        check("abort_ready", 32'(req_ready), 32'd2);
        req_valid[1] = 1'b0;
        tick();
        check("abort_e_high", 32'(TLCD_E), 32'd1);
        RESETN = 1'b0;
        #1;
        check("abort_e_async", 32'(TLCD_E), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data", 32'(TLCD_DATA), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("abort_no_done", 32'(req_done), 32'd0);
            check("abort_e_low", 32'(TLCD_E), 32'd0);
        end
        RESETN = 1'b1;
        tick();
        check("post_rst_done", 32'(req_done), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        req_rs1 = 1'b1; req_data1 = 8'h41; req_valid[1] = 1'b1;
        xfer(1'b1, 1'b1, 8'h41, SIM_EXEC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tlcd_bus_arbiter.md
TLCD_BUS_ARBITER -- requirements
Module: tlcd_bus_arbiter

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- T_SETUP, 2: cycles RS/DATA are stable before E rises.
- T_EH, 12: cycles E is held high.
- T_HOLD, 2: cycles RS/DATA are held after E falls.
- T_EXEC, 2000: post-write execution wait in cycles, for normal commands and data.
- T_CLEAR, 80000: post-write wait in cycles for RS=0 writes of 0x01 or 0x02.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- CLK, in, 1: single clock.
- RESETN, in, 1: asynchronous, active-low reset.
- req_valid[1:0], in, 2: per-port write request. Port 0 = font loader, port 1 = text controller.
- req_lock[1:0], in, 2: keep the grant after this transfer.
- req_rs0 / req_rs1, in, 1 each: register select for the port's write.
- req_data0 / req_data1, in, 8 each: byte to write.
- req_ready[1:0], out, 2: one-cycle accept pulse.
- req_done[1:0], out, 2: one-cycle pulse when the port's write, including its exec wait, has finished.
- grant_owner, out, 1: index of the port currently granted.
- busy, out, 1: high whenever the state is not IDLE.
- TLCD_E, TLCD_RS, TLCD_RW, out, 1 each: LCD control lines.
- TLCD_DATA, out, 8: LCD data bus.

Function
REQ-003 The FSM SHALL have states IDLE, SETUP, E_HIGH, HOLD, WAIT. Transitions:
- IDLE->SETUP on accept.
- SETUP->E_HIGH after T_SETUP cycles.
- E_HIGH->HOLD after T_EH cycles.
- HOLD->WAIT after T_HOLD cycles.
- WAIT->IDLE after the exec wait.

REQ-004 In IDLE, with no lock held and both req_valid bits high, port 0 SHALL win. With one bit high, that port SHALL win.

REQ-005 While a lock is held, only the owning port SHALL be accepted. The other port's req_valid SHALL be ignored, with its req_ready low.

REQ-006 On accept, the block SHALL do the following at the same clock edge:
- latch RS/DATA/lock from the winning port;
- pulse req_ready[port] for exactly one cycle, starting in the cycle after IDLE sampled valid;
- set grant_owner;
- enter SETUP.

REQ-007 A requester SHALL hold valid, rs and data stable until it sees req_ready. Inputs that change after accept SHALL have no effect on the transfer in progress.

REQ-008 TLCD_RS/TLCD_DATA SHALL drive the latched values from SETUP through HOLD, and keep them through WAIT. TLCD_E SHALL be high only in E_HIGH. TLCD_RW SHALL be constant 0.

REQ-009 The WAIT length SHALL be T_CLEAR when latched RS=0 and DATA is 0x01 or 0x02; otherwise it SHALL be T_EXEC.

REQ-010 On WAIT->IDLE, req_done[owner] SHALL pulse for one cycle.
- If the latched lock was 1, the lock SHALL stay with the owner.
- If the latched lock was 0, the lock SHALL be released at that same edge.

REQ-011 A request sampled in the cycle IDLE is re-entered SHALL be accepted with no extra bubble. Back-to-back occupancy per write SHALL be 1 + T_SETUP + T_EH + T_HOLD + wait cycles.

REQ-012 If the lock owner drops req_valid while holding the lock, the lock SHALL persist until that owner completes a write with lock=0. Starvation of the other port is the owner's responsibility.

REQ-013 All delay counts SHALL be at least 1. A parameter value of 0 SHALL be treated as 1.

REQ-014 Delay counters SHALL be 17 bits wide and SHALL count down to 0 without wrap-around.

REQ-015 req_ready and req_done SHALL never be asserted for both ports in the same cycle.

Reset
REQ-016 While RESETN=0, all of the following SHALL apply:
- state = IDLE;
- TLCD_E = 0, TLCD_RS = 0, TLCD_RW = 0, TLCD_DATA = 0x00;
- req_ready = 0, req_done = 0;
- busy = 0, grant_owner = 0;
- lock cleared, counters = 0.

REQ-017 Reset asserted mid-transfer SHALL drop TLCD_E immediately (asynchronously) and abort the transfer with no req_done. After release, the block SHALL resume in IDLE.

Structure
REQ-018 A shared package tlcd_pkg SHALL hold:
- the state encoding;
- the CLEAR (0x01) and HOME (0x02) command codes;
- the default timing constants.
The font loader and the text controller SHALL import the same package.

REQ-019 One sub-module, tlcd_delay_counter (load value, start, zero flag), SHALL implement every phase delay. The arbiter SHALL contain only the FSM, the arbitration and the latches.

Verification (sim parameters: T_SETUP=1, T_EH=3, T_HOLD=1, T_EXEC=4, T_CLEAR=20)
REQ-020 Single write: port 1 sends RS=1, DATA=0x41.
- req_ready[1] pulses one cycle later.
- TLCD_E is high for exactly 3 cycles, with DATA=0x41 and RS=1 stable from 1 cycle before E until 1 cycle after.
- req_done[1] pulses 4 cycles after HOLD ends.

REQ-021 Clear timing: port 0 sends RS=0, DATA=0x01.
- WAIT lasts 20 cycles.
- A following RS=0, DATA=0x0C write waits 4 cycles.

REQ-022 Contention: both ports are valid in the same IDLE cycle.
- Port 0 is accepted first.
- Port 1 is accepted in the cycle after req_done[0].
- req_ready is never asserted for both ports at once.

REQ-023 Lock burst: port 0 sends 9 writes (CGRAM address 0x40, then 8 pattern bytes), with lock=1 on the first 8 and lock=0 on the last. Port 1 stays valid throughout.
- Port 1 is accepted only after the 9th req_done[0].
- grant_owner stays 0 throughout the burst.

REQ-024 Reset mid-operation: RESETN is pulled low during E_HIGH.
- TLCD_E goes to 0 in the same cycle, with no req_done.
- After release, a new port 1 write completes normally.

REQ-025 Stability: port 1 changes DATA from 0x41 to 0x42 after req_ready. TLCD_DATA stays 0x41 for the whole transfer.
